test_card_sequencer: RTL and testbench

Frame-synchronous source scheduler for the display pipeline. It sits between the test card generators and the DVI/VGA output stage, selects one of `N_SRC` pixel sources, and changes source only at frame boundaries. Change requests come from three requesters: a direct-select handshake, a debounced push button, and an auto-cycle timer. After each switch the block inserts one fully blanked frame, so no frame ever mixes two sources.

---
 rtl/test_card_sequencer_pkg.sv | 19 +
 rtl/button_debounce.sv | 50 +++++
 rtl/test_card_sequencer.sv | 128 ++++++++++++
 tb/tb_test_card_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_card_sequencer_pkg.sv
// ============================================================================
// test_card_sequencer_pkg : shared state encoding and pixel slice width
// Rev 1.0
// ============================================================================
`default_nettype none

package test_card_sequencer_pkg;

   typedef enum logic [1:0] {
      SHOW  = 2'd0,
      PEND  = 2'd1,
      BLANK = 2'd2
   } seq_state_t;

   localparam int RGB_W = 24;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce : two-flop synchroniser, stability counter, rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
   parameter int DB_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_rise
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         cnt     <= '0;
         o_level <= 1'b0;
         o_rise  <= 1'b0;
      end else begin
         sync1  <= i_btn;
         sync2  <= sync1;
         o_rise <= 1'b0;
         // cnt tracks how long sync2 has disagreed with the accepted level
         if (sync2 == o_level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            o_level <= sync2;
            o_rise  <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/test_card_sequencer.sv
// ============================================================================
// test_card_sequencer : picks one of N_SRC pixel sources, switching only at
// frame boundaries with one blanked frame in between.  Rev 1.0
// ============================================================================
`default_nettype none

module test_card_sequencer
   import test_card_sequencer_pkg::*;
#(
   parameter  int N_SRC       = 4,
   parameter  int HOLD_FRAMES = 120,
   parameter  int DB_CYCLES   = 250000,
   localparam int SW          = $clog2(N_SRC)
) (
   input  logic                     i_pix_clk,
   input  logic                     i_rst,
   input  logic                     i_frame,
   input  logic                     i_hs,
   input  logic                     i_vs,
   input  logic                     i_de,
   input  logic                     i_btn,
   input  logic                     i_auto,
   input  logic                     i_sel_valid,
   input  logic [SW-1:0]            i_sel,
   output logic                     o_sel_ready,
   input  logic [RGB_W*N_SRC-1:0]   i_rgb,
   output logic [7:0]               o_red,
   output logic [7:0]               o_green,
   output logic [7:0]               o_blue,
   output logic                     o_hs,
   output logic                     o_vs,
   output logic                     o_de,
   output logic [SW-1:0]            o_src,
   output logic                     o_switch
);

   localparam int CW = $clog2(HOLD_FRAMES + 1);
   localparam logic [SW-1:0] LAST_IDX  = SW'(N_SRC - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

   seq_state_t           state, state_nxt;
   logic [SW-1:0]        tgt, tgt_nxt, next_idx;
   logic [CW-1:0]        auto_cnt;
   logic                 btn_level, btn_rise;
   logic                 sel_acc, sel_in_range, auto_hit, show_pix;
   logic [RGB_W-1:0]     src_pix [N_SRC];

   genvar k;
   generate
      for (k = 0; k < N_SRC; k++) begin : g_unpack
         assign src_pix[k] = i_rgb[k*RGB_W +: RGB_W];
      end
   endgenerate

   button_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn (
      .i_clk   (i_pix_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn),
      .o_level (btn_level),
      .o_rise  (btn_rise)
   );

   always_comb begin
      state_nxt    = state;
      tgt_nxt      = tgt;
      next_idx     = (o_src == LAST_IDX) ? '0 : o_src + 1'b1;
      o_sel_ready  = (state == SHOW) && !i_rst;
      sel_acc      = i_sel_valid && o_sel_ready;
      sel_in_range = (int'(i_sel) < N_SRC);
      auto_hit     = i_auto && i_frame && (auto_cnt == HOLD_LAST);
      case (state)
         SHOW: begin
            // an out-of-range select still consumes the slot, masking the button
            if (sel_acc) begin
               if (sel_in_range) begin
                  state_nxt = PEND;
                  tgt_nxt   = i_sel;
               end
            end else if (btn_rise && btn_level) begin
               state_nxt = PEND;
               tgt_nxt   = next_idx;
            end else if (auto_hit) begin
               state_nxt = PEND;
               tgt_nxt   = next_idx;
            end
         end
         PEND:    if (i_frame) state_nxt = BLANK;
         BLANK:   if (i_frame) state_nxt = SHOW;
         default: state_nxt = SHOW;
      endcase
      // look ahead one state so the first SHOW cycle after BLANK carries pixels
      show_pix = i_de && (state_nxt != BLANK);
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         state    <= SHOW;
         tgt      <= '0;
         o_src    <= '0;
         o_switch <= 1'b0;
         auto_cnt <= '0;
         o_red    <= '0;
         o_green  <= '0;
         o_blue   <= '0;
         o_hs     <= 1'b0;
         o_vs     <= 1'b0;
         o_de     <= 1'b0;
      end else begin
         state    <= state_nxt;
         tgt      <= tgt_nxt;
         o_switch <= (state == PEND) && i_frame;
         if ((state == PEND) && i_frame) o_src <= tgt;
         if ((state != SHOW) || (state_nxt != SHOW) || !i_auto)
            auto_cnt <= '0;
         else if (i_frame)
            auto_cnt <= auto_cnt + 1'b1;
         o_hs <= i_hs;
         o_vs <= i_vs;
         o_de <= i_de;
         {o_red, o_green, o_blue} <= show_pix ? src_pix[o_src] : '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_test_card_sequencer.sv
// ============================================================================
// tb_test_card_sequencer : directed bench for the frame-synchronous sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_test_card_sequencer;

   localparam int FP = 16;

   logic        clk = 1'b0;
   logic        rst, i_frame, i_hs, i_vs, i_de, btn, auto_en, sel_valid;
   logic [1:0]  sel;
   logic [95:0] rgb;
   logic        sel_ready, o_hs, o_vs, o_de, o_switch;
   logic [7:0]  o_red, o_green, o_blue;
   logic [1:0]  o_src;

   logic        b_sel_valid;
   logic [1:0]  b_sel;
   logic [71:0] b_rgb;
   logic        b_ready, b_hs, b_vs, b_de, b_switch;
   logic [7:0]  b_red, b_green, b_blue;
   logic [1:0]  b_src;

   int   n_chk = 0, n_fail = 0;
   int   pos = 0, pos_prev = 0, sw_cnt = 0, sw_b = 0, nf = 0;
   logic fr_prev = 1'b0, de_prev = 1'b0;

   always #5 clk = ~clk;

   test_card_sequencer #(.N_SRC(4), .HOLD_FRAMES(3), .DB_CYCLES(8)) dut (
      .i_pix_clk(clk), .i_rst(rst), .i_frame(i_frame), .i_hs(i_hs), .i_vs(i_vs),
      .i_de(i_de), .i_btn(btn), .i_auto(auto_en), .i_sel_valid(sel_valid),
      .i_sel(sel), .o_sel_ready(sel_ready), .i_rgb(rgb), .o_red(o_red),
      .o_green(o_green), .o_blue(o_blue), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
      .o_src(o_src), .o_switch(o_switch)
   );

   test_card_sequencer #(.N_SRC(3), .HOLD_FRAMES(3), .DB_CYCLES(8)) dut_b (
      .i_pix_clk(clk), .i_rst(rst), .i_frame(i_frame), .i_hs(i_hs), .i_vs(i_vs),
      .i_de(i_de), .i_btn(1'b0), .i_auto(1'b0), .i_sel_valid(b_sel_valid),
      .i_sel(b_sel), .o_sel_ready(b_ready), .i_rgb(b_rgb), .o_red(b_red),
      .o_green(b_green), .o_blue(b_blue), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de),
      .o_src(b_src), .o_switch(b_switch)
   );

   function automatic logic [23:0] pix(input int k, input int p);
      logic [7:0] r, g, b;
      r = 8'(16 * k + p);
      g = 8'(p) ^ 8'hA0;
      b = 8'(8'h40 + k);
      return {r, g, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_timing();
      i_frame = (pos == 0);
      i_de    = (pos < 12);
      i_hs    = (pos == 12) || (pos == 13);
      i_vs    = (pos == 14);
      for (int k = 0; k < 4; k++) rgb[24*k +: 24] = pix(k, pos);
      b_rgb = rgb[71:0];
   endtask

   // one clock: sample just after the edge, then drive the next cycle's timing
   task automatic tick();
      logic [2:0] sync_exp;
      @(posedge clk);
      #1;
      fr_prev  = i_frame;
      de_prev  = i_de;
      pos_prev = pos;
      if (o_switch) sw_cnt++;
      if (b_switch) sw_b++;
      sync_exp = rst ? 3'b000 : {i_hs, i_vs, i_de};
      chk("sync_delay", {o_hs, o_vs, o_de}, sync_exp);
      chk("sync_delay_b", {b_hs, b_vs, b_de}, sync_exp);
      pos = (pos + 1) % FP;
      drive_timing();
   endtask

   task automatic wait_frame(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!fr_prev && n < 3 * FP);
      chk(tag, fr_prev, 1);
   endtask

   task automatic tick_to(input int p);
      int n = 0;
      do begin
         tick();
         n++;
      end while (pos_prev != p && n < FP + 1);
   endtask

   task automatic wait_switch(output int frames);
      int n = 0;
      frames = 0;
      do begin
         tick();
         n++;
         if (fr_prev) frames++;
      end while (!o_switch && n < 8 * FP);
      chk("auto_switch_seen", o_switch, 1);
   endtask

   initial begin
      rst = 1'b1; btn = 1'b0; auto_en = 1'b0; sel_valid = 1'b0; sel = 2'd0;
      b_sel_valid = 1'b0; b_sel = 2'd0; rgb = '0; b_rgb = '0;
      drive_timing();

      // reset with live pixel data
      repeat (2) tick();
      chk("rst_colour", {o_red, o_green, o_blue}, 0);
      chk("rst_src", o_src, 0);
      chk("rst_switch", o_switch, 0);
      chk("rst_ready", sel_ready, 0);
      chk("rst_ready_b", b_ready, 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", sel_ready, 1);
      chk("ready_after_rst_b", b_ready, 1);
      chk("show_src0", {o_red, o_green, o_blue}, de_prev ? pix(0, pos_prev) : 24'h0);

      // direct select of source 2, mid-frame
      while (pos != 5) tick();
      sel_valid = 1'b1; sel = 2'd2;
      tick();
      sel_valid = 1'b0;
      chk("pend_ready", sel_ready, 0);
      chk("pend_src", o_src, 0);
      chk("pend_colour_old", {o_red, o_green, o_blue}, pix(0, 5));
      wait_frame("f1_timeout");
      chk("f1_src", o_src, 2);
      chk("f1_switch", o_switch, 1);
      chk("f1_black", {o_red, o_green, o_blue}, 0);
      tick();
      chk("switch_single", o_switch, 0);
      tick_to(6);
      chk("blank_colour", {o_red, o_green, o_blue}, 0);
      chk("blank_ready", sel_ready, 0);
      wait_frame("f2_timeout");
      chk("f2_colour", {o_red, o_green, o_blue}, pix(2, 0));
      chk("f2_ready", sel_ready, 1);
      chk("switch_count_1", sw_cnt, 1);

      // pixel gating with display enable low
      tick_to(13);
      chk("de_gate", {o_red, o_green, o_blue}, 0);
      tick_to(3);
      chk("src2_colour", {o_red, o_green, o_blue}, pix(2, 3));

      // short glitches must not advance
      for (int g = 0; g < 2; g++) begin
         btn = 1'b1; repeat (5) tick();
         btn = 1'b0; repeat (12) tick();
      end
      chk("glitch_src", o_src, 2);
      chk("glitch_switch", sw_cnt, 1);

      // a held press advances once; release and re-press advances again
      btn = 1'b1; repeat (20) tick();
      btn = 1'b0; repeat (60) tick();
      chk("press1_src", o_src, 3);
      chk("press1_switch", sw_cnt, 2);
      chk("press1_ready", sel_ready, 1);
      btn = 1'b1; repeat (20) tick();
      btn = 1'b0; repeat (60) tick();
      chk("press2_wrap_src", o_src, 0);
      chk("press2_switch", sw_cnt, 3);

      // button event coincides with a direct select of 3
      btn = 1'b1; repeat (10) tick();
      sel_valid = 1'b1; sel = 2'd3;
      tick();
      sel_valid = 1'b0;
      chk("collide_ready", sel_ready, 0);
      repeat (10) tick();
      btn = 1'b0; repeat (60) tick();
      chk("collide_src", o_src, 3);
      chk("collide_switch", sw_cnt, 4);

      // selecting the active source still runs a full switch
      sel_valid = 1'b1; sel = 2'd3;
      tick();
      sel_valid = 1'b0;
      repeat (40) tick();
      chk("same_src", o_src, 3);
      chk("same_switch", sw_cnt, 5);

      // out-of-range select on the three-source instance
      chk("b_ready_pre", b_ready, 1);
      b_sel_valid = 1'b1; b_sel = 2'd3;
      tick();
      b_sel_valid = 1'b0;
      chk("b_oor_stays_show", b_ready, 1);
      repeat (40) tick();
      chk("b_oor_src", b_src, 0);
      chk("b_oor_switch", sw_b, 0);

      // reset during BLANK
      sel_valid = 1'b1; sel = 2'd1;
      tick();
      sel_valid = 1'b0;
      wait_frame("mid_f1_timeout");
      chk("mid_src_before", o_src, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_src", o_src, 0);
      chk("mid_rst_ready", sel_ready, 0);
      rst = 1'b0; auto_en = 1'b1;

      // auto cycling 0->1->2->3->0
      for (int s = 1; s <= 4; s++) begin
         wait_switch(nf);
         chk("auto_frames", nf, (s == 1) ? 4 : 5);
         chk("auto_src", o_src, s % 4);
      end
      auto_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
